vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator; successor to the fixed 640x480 scanner.
//  Derives a pixel clock-enable from clk via phase accumulator, produces hs/vs/de/x/y.
//  Adds configurable sync polarity, run/stop control, frame/line strobes and a frame counter.
//  Sits between the system clock domain and the framebuffer reader / VGA pins.
// PARAMETERS
//  HD 640 / HF 16 / HS 96 / HB 48 : horizontal active, front porch, sync, back porch (pixels)
//  VD 480 / VF 10 / VS 2 / VB 33  : vertical active, front porch, sync, back porch (lines)
//  HS_POL 0, VS_POL 0             : sync active level (0 = active-low)
//  ACC_W 16                       : phase accumulator width
//  CE_INC 16'h4000                : accumulator increment; ce rate = clk*CE_INC/2^ACC_W (25 MHz @100 MHz)
//  XY_W 16                        : width of x, y and internal counters
//  FRAME_W 8                      : frame counter width
// PORTS
//  clk          in   1        system clock (100 MHz nominal)
//  rst          in   1        reset, asynchronous, active-low
//  run          in   1        1 = scan; 0 = hold idle at end-of-frame
//  hs           out  1        horizontal sync, level per HS_POL
//  vs           out  1        vertical sync, level per VS_POL
//  de           out  1        display enable (active region)
//  x            out  XY_W     pixel column, 0 when de=0
//  y            out  XY_W     pixel row, 0 when de=0
//  line_start   out  1        1-clk pulse when hc becomes 0
//  frame_start  out  1        1-clk pulse when (hc,vc) becomes (0,0)
//  frame_cnt    out  FRAME_W  frames started, wraps modulo 2^FRAME_W
// BEHAVIOUR
//  - H_TOTAL=HD+HF+HS+HB, V_TOTAL=VD+VF+VS+VB (localparams).
//  - Accumulator: {ce,acc} <= acc + CE_INC each clk; ce is 1-clk pulse, carry out of ACC_W bits.
//  - On ce: hc==H_TOTAL-1 -> hc=0 and vc=(vc==V_TOTAL-1)?0:vc+1; else hc=hc+1. No change w/o ce.
//  - Reset (async, rst=0): acc=0, hc=H_TOTAL-1, vc=V_TOTAL-1, frame_cnt=0; outputs idle:
//    de=0, x=y=0, hs=~HS_POL, vs=~VS_POL, strobes 0. First ce after release -> (0,0).
//  - All outputs registered, decoded from next-state counters: change on same edge as hc/vc,
//    zero skew between them. de=(hc<HD)&&(vc<VD); hs active for HD+HF<=hc<HD+HF+HS;
//    vs active for VD+VF<=vc<VD+VF+VS (vs changes only with hc wrap).
//  - line_start/frame_start: high exactly one clk (not one ce period); frame_cnt incs same edge.
//  - run=0 (sampled synchronously): next edge forces hc/vc to reset state, outputs idle,
//    strobes suppressed; acc keeps running. run 0->1: scanning resumes at first ce -> (0,0)
//    with frame_start. Mid-frame run drop abandons the frame; no partial-frame recovery.
//  - run=0 on same cycle as ce: run wins.
//  - Counters compare with >= on wrap so out-of-range state self-corrects within one ce.
// CONFIGURATION
//  VGA_LOOKAHEAD_EN defined: extra outputs la_de (1), la_x, la_y (XY_W) = values de/x/y take at
//  the next ce, held between ces; idle values in reset/run=0 = (1,0,0) when next ce enters (0,0).
//  Lets a 1-ce-latency framebuffer read align with de. Undefined: ports absent, no logic.
// STRUCTURE
//  Shared package vga_pkg: default 640x480@60 timing constants, 800x600 set, polarity codes,
//  CE_INC values for 100 MHz clk.
//  Sub-module pix_ce_gen (ACC_W, CE_INC): phase accumulator, ports clk, rst, ce.
//  Top holds counters, run logic, output decode registers, frame counter.
// TESTING
//  1 Defaults, release rst at t0 -> ce every 4 clk; first ce: frame_start=1, de=1, x=0, y=0, frame_cnt=1.
//  2 Line: hs low for exactly 96 ces starting hc=656; line_start period 3200 clk; de high 640 ces/line.
//  3 Frame: vs low on lines 490-491; frame_start period 525*3200 clk; 307200 de ces/frame; frame_cnt 2->3.
//  4 run=0 at (x=100,y=200) -> next edge de=0, hs=vs=1, x=y=0, no strobes; run=1 -> next ce (0,0)+frame_start.
//  5 Assert rst mid-line between clk edges -> outputs idle immediately; HS_POL=VS_POL=1 build: idle hs=vs=0.
//  6 HD=4,HF=1,HS=1,HB=2,VD=3,VF=1,VS=1,VB=1,CE_INC=16'h8000 with VGA_LOOKAHEAD_EN:
//    ce every 2 clk, H_TOTAL=8, V_TOTAL=6; la_x/la_de equal x/de one ce later across line and frame wrap.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared raster timing constants for vga_timing_gen: standard mode timings,
// sync polarity codes and pixel clock-enable increments for a 100 MHz clk.
package vga_pkg;

  // Sync polarity codes: the level a sync output takes while active.
  localparam logic POL_ACTIVE_LOW  = 1'b0;
  localparam logic POL_ACTIVE_HIGH = 1'b1;

  // 640x480 @ 60 Hz, 25 MHz pixel clock (default timing).
  localparam int VGA640_HD = 640;
  localparam int VGA640_HF = 16;
  localparam int VGA640_HS = 96;
  localparam int VGA640_HB = 48;
  localparam int VGA640_VD = 480;
  localparam int VGA640_VF = 10;
  localparam int VGA640_VS = 2;
  localparam int VGA640_VB = 33;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs.
  localparam int SVGA800_HD = 800;
  localparam int SVGA800_HF = 40;
  localparam int SVGA800_HS = 128;
  localparam int SVGA800_HB = 88;
  localparam int SVGA800_VD = 600;
  localparam int SVGA800_VF = 1;
  localparam int SVGA800_VS = 4;
  localparam int SVGA800_VB = 23;

  // Phase accumulator increments (16-bit accumulator, 100 MHz clk).
  localparam logic [15:0] CE_INC_25M_AT_100M = 16'h4000;
  localparam logic [15:0] CE_INC_40M_AT_100M = 16'h6666;

endpackage

// File: rtl/pix_ce_gen.sv
// Pixel clock-enable generator: a phase accumulator whose carry out becomes a
// single-clk ce pulse. Average ce rate is clk * CE_INC / 2^ACC_W.
module pix_ce_gen #(
  parameter int               ACC_W  = 16,
  parameter logic [ACC_W-1:0] CE_INC = 16'h4000
) (
  input  logic clk,
  input  logic rst,   // asynchronous, active-low
  output logic ce
);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W:0]   sum_s;

  assign sum_s = {1'b0, acc_r} + {1'b0, CE_INC};

  // Advance the accumulator every clk; the carry out is registered as ce.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= '0;
      ce    <= 1'b0;
    end else begin
      acc_r <= sum_s[ACC_W-1:0];
      ce    <= sum_s[ACC_W];
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator. Counters hc/vc advance on the pixel
// clock-enable from pix_ce_gen; every output is registered from the next-state
// counters so hs/vs/de/x/y and the strobes change together with hc/vc.
// Optional feature macro: VGA_LOOKAHEAD_EN adds la_de/la_x/la_y, the values
// de/x/y will take at the following ce.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int               HD      = VGA640_HD,
  parameter int               HF      = VGA640_HF,
  parameter int               HS      = VGA640_HS,
  parameter int               HB      = VGA640_HB,
  parameter int               VD      = VGA640_VD,
  parameter int               VF      = VGA640_VF,
  parameter int               VS      = VGA640_VS,
  parameter int               VB      = VGA640_VB,
  parameter logic             HS_POL  = POL_ACTIVE_LOW,
  parameter logic             VS_POL  = POL_ACTIVE_LOW,
  parameter int               ACC_W   = 16,
  parameter logic [ACC_W-1:0] CE_INC  = CE_INC_25M_AT_100M,
  parameter int               XY_W    = 16,
  parameter int               FRAME_W = 8
) (
  input  logic               clk,
  input  logic               rst,          // asynchronous, active-low
  input  logic               run,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic [XY_W-1:0]    x,
  output logic [XY_W-1:0]    y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
`ifdef VGA_LOOKAHEAD_EN
  ,
  output logic               la_de,
  output logic [XY_W-1:0]    la_x,
  output logic [XY_W-1:0]    la_y
`endif
);

  localparam int H_TOTAL = HD + HF + HS + HB;
  localparam int V_TOTAL = VD + VF + VS + VB;

  localparam logic [XY_W-1:0]    H_LAST    = XY_W'(H_TOTAL - 1);
  localparam logic [XY_W-1:0]    V_LAST    = XY_W'(V_TOTAL - 1);
  localparam logic [XY_W-1:0]    H_ACT_END = XY_W'(HD);
  localparam logic [XY_W-1:0]    V_ACT_END = XY_W'(VD);
  localparam logic [XY_W-1:0]    H_SYNC_LO = XY_W'(HD + HF);
  localparam logic [XY_W-1:0]    H_SYNC_HI = XY_W'(HD + HF + HS);
  localparam logic [XY_W-1:0]    V_SYNC_LO = XY_W'(VD + VF);
  localparam logic [XY_W-1:0]    V_SYNC_HI = XY_W'(VD + VF + VS);
  localparam logic [XY_W-1:0]    XY_ONE    = XY_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

  // Column after hc; >= so an out-of-range column wraps straight to 0.
  function automatic logic [XY_W-1:0] step_h(input logic [XY_W-1:0] hc);
    if (hc >= H_LAST) begin
      return '0;
    end else begin
      return hc + XY_ONE;
    end
  endfunction

  // Row after (hc,vc); the row only moves when the column wraps.
  function automatic logic [XY_W-1:0] step_v(input logic [XY_W-1:0] hc,
                                             input logic [XY_W-1:0] vc);
    if (hc < H_LAST) begin
      return vc;
    end else if (vc >= V_LAST) begin
      return '0;
    end else begin
      return vc + XY_ONE;
    end
  endfunction

  logic                ce;
  logic [XY_W-1:0]     hc_r, vc_r;
  logic [XY_W-1:0]     hc_nxt_s, vc_nxt_s;
  logic                adv_s;
  logic                de_nxt_s, hs_nxt_s, vs_nxt_s;
  logic [XY_W-1:0]     x_nxt_s, y_nxt_s;
  logic                ls_nxt_s, fs_nxt_s;
  logic [FRAME_W-1:0]  fc_nxt_s;

  pix_ce_gen #(
    .ACC_W  (ACC_W),
    .CE_INC (CE_INC)
  ) u_ce (
    .clk (clk),
    .rst (rst),
    .ce  (ce)
  );

  // Next counter state: run=0 parks at the last position (even on a ce),
  // otherwise a ce steps one pixel through the raster.
  always_comb begin
    hc_nxt_s = hc_r;
    vc_nxt_s = vc_r;
    adv_s    = 1'b0;
    if (!run) begin
      hc_nxt_s = H_LAST;
      vc_nxt_s = V_LAST;
    end else if (ce) begin
      adv_s    = 1'b1;
      hc_nxt_s = step_h(hc_r);
      vc_nxt_s = step_v(hc_r, vc_r);
    end else begin
      hc_nxt_s = hc_r;
      vc_nxt_s = vc_r;
    end
  end

  // Output decode of the next-state counters; idle values while stopped.
  always_comb begin
    de_nxt_s = 1'b0;
    hs_nxt_s = ~HS_POL;
    vs_nxt_s = ~VS_POL;
    x_nxt_s  = '0;
    y_nxt_s  = '0;
    ls_nxt_s = 1'b0;
    fs_nxt_s = 1'b0;
    fc_nxt_s = frame_cnt;
    if (run) begin
      de_nxt_s = (hc_nxt_s < H_ACT_END) && (vc_nxt_s < V_ACT_END);
      hs_nxt_s = ((hc_nxt_s >= H_SYNC_LO) && (hc_nxt_s < H_SYNC_HI)) ? HS_POL : ~HS_POL;
      vs_nxt_s = ((vc_nxt_s >= V_SYNC_LO) && (vc_nxt_s < V_SYNC_HI)) ? VS_POL : ~VS_POL;
      x_nxt_s  = de_nxt_s ? hc_nxt_s : '0;
      y_nxt_s  = de_nxt_s ? vc_nxt_s : '0;
      ls_nxt_s = adv_s && (hc_nxt_s == '0);
      fs_nxt_s = ls_nxt_s && (vc_nxt_s == '0);
      fc_nxt_s = fs_nxt_s ? (frame_cnt + FRAME_ONE) : frame_cnt;
    end else begin
      fc_nxt_s = frame_cnt;
    end
  end

  // Counter and output registers; reset lands on the idle end-of-frame state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hc_r        <= H_LAST;
      vc_r        <= V_LAST;
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      hc_r        <= hc_nxt_s;
      vc_r        <= vc_nxt_s;
      de          <= de_nxt_s;
      hs          <= hs_nxt_s;
      vs          <= vs_nxt_s;
      x           <= x_nxt_s;
      y           <= y_nxt_s;
      line_start  <= ls_nxt_s;
      frame_start <= fs_nxt_s;
      frame_cnt   <= fc_nxt_s;
    end
  end

`ifdef VGA_LOOKAHEAD_EN
  logic [XY_W-1:0] la_h_s, la_v_s;
  logic            la_de_nxt_s;
  logic [XY_W-1:0] la_x_nxt_s, la_y_nxt_s;

  // Position one ce beyond the next state; from the parked state this is (0,0).
  always_comb begin
    la_h_s      = step_h(hc_nxt_s);
    la_v_s      = step_v(hc_nxt_s, vc_nxt_s);
    la_de_nxt_s = (la_h_s < H_ACT_END) && (la_v_s < V_ACT_END);
    la_x_nxt_s  = '0;
    la_y_nxt_s  = '0;
    if (la_de_nxt_s) begin
      la_x_nxt_s = la_h_s;
      la_y_nxt_s = la_v_s;
    end else begin
      la_x_nxt_s = '0;
      la_y_nxt_s = '0;
    end
  end

  // Lookahead registers, updated on the same edge as the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      la_de <= 1'b1;
      la_x  <= '0;
      la_y  <= '0;
    end else begin
      la_de <= la_de_nxt_s;
      la_x  <= la_x_nxt_s;
      la_y  <= la_y_nxt_s;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a small raster. The reference model
// tracks the linear raster position (pixel index within the frame) and the
// accumulator carry as plain arithmetic on the clk edge count.
module tb_vga_timing_gen;

  localparam int HD = 12, HF = 2, HS = 3, HB = 3;
  localparam int VD = 5,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int TOT = HT * VT;
  localparam logic HS_P = 1'b1;
  localparam logic VS_P = 1'b0;
  localparam longint INC = 64'h5000;
  localparam int XY_W = 16;
  localparam int FRAME_W = 3;
  localparam int N_CYC = 20000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b1;
  logic hs, vs, de, line_start, frame_start;
  logic [XY_W-1:0] x, y;
  logic [FRAME_W-1:0] frame_cnt;
`ifdef VGA_LOOKAHEAD_EN
  logic la_de;
  logic [XY_W-1:0] la_x, la_y;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  longint e_cnt;
  int     pos;
  int     fc;
  bit     m_ls, m_fs, m_idle;
  int     hold;

  vga_timing_gen #(
    .HD(HD), .HF(HF), .HS(HS), .HB(HB),
    .VD(VD), .VF(VF), .VS(VS), .VB(VB),
    .HS_POL(HS_P), .VS_POL(VS_P),
    .ACC_W(16), .CE_INC(16'h5000),
    .XY_W(XY_W), .FRAME_W(FRAME_W)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
`ifdef VGA_LOOKAHEAD_EN
    , .la_de(la_de), .la_x(la_x), .la_y(la_y)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // True when the accumulator carried on clk edge n (n counted from reset release).
  function automatic bit carry(input longint n);
    if (n <= 0) return 1'b0;
    return ((n * INC) >> 16) != (((n - 1) * INC) >> 16);
  endfunction

  task automatic model_reset();
    e_cnt  = 0;
    pos    = TOT - 1;
    fc     = 0;
    m_ls   = 1'b0;
    m_fs   = 1'b0;
    m_idle = 1'b1;
  endtask

  // One clk edge: ce seen at this edge is the carry of the previous edge.
  task automatic model_edge();
    bit ce_seen;
    e_cnt++;
    ce_seen = carry(e_cnt - 1);
    m_ls = 1'b0;
    m_fs = 1'b0;
    if (!run) begin
      pos    = TOT - 1;
      m_idle = 1'b1;
    end else begin
      m_idle = 1'b0;
      if (ce_seen) begin
        pos  = (pos + 1) % TOT;
        m_ls = (pos % HT) == 0;
        m_fs = (pos == 0);
        if (m_fs) fc = (fc + 1) % (1 << FRAME_W);
      end
    end
  endtask

  task automatic check_all(input string tag);
    int  hc, vc, h2, v2;
    bit  e_de, e_hs, e_vs, la_e;
    hc = pos % HT;
    vc = pos / HT;
    e_de = !m_idle && (hc < HD) && (vc < VD);
    e_hs = (!m_idle && hc >= HD + HF && hc < HD + HF + HS) ? HS_P : !HS_P;
    e_vs = (!m_idle && vc >= VD + VF && vc < VD + VF + VS) ? VS_P : !VS_P;
    check({tag, ".de"}, de, e_de);
    check({tag, ".hs"}, hs, e_hs);
    check({tag, ".vs"}, vs, e_vs);
    check({tag, ".x"}, x, e_de ? hc : 0);
    check({tag, ".y"}, y, e_de ? vc : 0);
    check({tag, ".line_start"}, line_start, m_ls);
    check({tag, ".frame_start"}, frame_start, m_fs);
    check({tag, ".frame_cnt"}, frame_cnt, fc);
    h2 = ((pos + 1) % TOT) % HT;
    v2 = ((pos + 1) % TOT) / HT;
    la_e = (h2 < HD) && (v2 < VD);
`ifdef VGA_LOOKAHEAD_EN
    check({tag, ".la_de"}, la_de, la_e);
    check({tag, ".la_x"}, la_x, la_e ? h2 : 0);
    check({tag, ".la_y"}, la_y, la_e ? v2 : 0);
`endif
  endtask

  initial begin
    model_reset();
    hold = 0;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b1;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all("scan");
      if (cyc == N_CYC / 2) begin
        // asynchronous reset asserted between edges must idle outputs at once
        #2 rst = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_all("in_rst");
        rst = 1'b1;
      end else if (run && $urandom_range(0, 1499) == 0) begin
        run  = 1'b0;
        hold = $urandom_range(1, 12);
      end else if (!run) begin
        hold--;
        if (hold <= 0) run = 1'b1;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
